// File: rtl/branch_sequencer.sv
// Branch resolution sequencer: takes one decoded branch at a time, waits for final ALU flags,
// drives the registered condition checker, then issues the PC redirect and a fixed flush window.
module branch_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic              flags_pending,
    output logic [3:0]        chk_cond,
    input  logic              chk_taken,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              busy,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt
);

    localparam logic [3:0] COND_ALWAYS = 4'b1110;
    localparam logic [3:0] COND_NEVER  = 4'b1111;

    // FLUSH lasts FLUSH_CYCLES-1 cycles; the counter runs from FLUSH_LOAD down to zero.
    localparam int FLUSH_LOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
    localparam int FC_W       = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FLAGS,
        S_EVAL,
        S_RESOLVE,
        S_REDIRECT,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cond_q, cond_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  taken_q, taken_d;
    logic [CNT_W-1:0]  not_taken_q, not_taken_d;
    logic              inc_taken, inc_not_taken;
    logic [ADDR_W-1:0] br_target;

    assign br_target = br_pc + ADDR_W'(4) + br_offset;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        cond_d        = cond_q;
        target_d      = target_q;
        rpc_d         = rpc_q;
        fcnt_d        = fcnt_q;
        inc_taken     = 1'b0;
        inc_not_taken = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    cond_d   = br_cond;
                    target_d = br_target;
                    if (br_cond == COND_ALWAYS) begin
                        state_d   = S_REDIRECT;
                        rpc_d     = br_target;
                        inc_taken = 1'b1;
                    end else if (br_cond == COND_NEVER) begin
                        inc_not_taken = 1'b1;
                    end else if (flags_pending) begin
                        state_d = S_WAIT_FLAGS;
                    end else begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_WAIT_FLAGS: begin
                if (!flags_pending) state_d = S_EVAL;
            end
            S_EVAL: begin
                state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (chk_taken) begin
                    state_d   = S_REDIRECT;
                    rpc_d     = target_q;
                    inc_taken = 1'b1;
                end else begin
                    state_d       = S_IDLE;
                    inc_not_taken = 1'b1;
                end
            end
            S_REDIRECT: begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_LOAD);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == '0) state_d = S_IDLE;
                else              fcnt_d  = fcnt_q - FC_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Clear beats a coincident increment; both counters stick at all-ones.
    always_comb begin
        taken_d     = taken_q;
        not_taken_d = not_taken_q;
        if (clr_stats) begin
            taken_d     = '0;
            not_taken_d = '0;
        end else begin
            if (inc_taken && (taken_q != '1))         taken_d     = taken_q + CNT_W'(1);
            if (inc_not_taken && (not_taken_q != '1)) not_taken_d = not_taken_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cond_q      <= '0;
            target_q    <= '0;
            rpc_q       <= '0;
            fcnt_q      <= '0;
            taken_q     <= '0;
            not_taken_q <= '0;
        end else begin
            state_q     <= state_d;
            cond_q      <= cond_d;
            target_q    <= target_d;
            rpc_q       <= rpc_d;
            fcnt_q      <= fcnt_d;
            taken_q     <= taken_d;
            not_taken_q <= not_taken_d;
        end
    end

    assign br_ready       = rst_n && (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign redirect_valid = (state_q == S_REDIRECT);
    assign flush          = (state_q == S_REDIRECT) || (state_q == S_FLUSH);
    assign chk_cond       = cond_q;
    assign redirect_pc    = rpc_q;
    assign taken_cnt      = taken_q;
    assign not_taken_cnt  = not_taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: a registered Z/C/N/V checker, a per-transaction schedule model,
// directed scenarios with literal expectations, then randomized branches.
module tb_branch_sequencer;

    localparam int ADDR_W       = 32;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              br_valid = 1'b0;
    logic              br_ready;
    logic [3:0]        br_cond = '0;
    logic [ADDR_W-1:0] br_pc = '0;
    logic [ADDR_W-1:0] br_offset = '0;
    logic              flags_pending = 1'b0;
    logic [3:0]        chk_cond;
    logic              chk_taken = 1'b0;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic              busy;
    logic              clr_stats = 1'b0;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  not_taken_cnt;

    logic fz = 1'b0, fc = 1'b0, fn = 1'b0, fv = 1'b0;

    always #5 clk = ~clk;

    branch_sequencer #(
        .ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .br_cond(br_cond), .br_pc(br_pc), .br_offset(br_offset),
        .flags_pending(flags_pending), .chk_cond(chk_cond), .chk_taken(chk_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .busy(busy), .clr_stats(clr_stats), .taken_cnt(taken_cnt),
        .not_taken_cnt(not_taken_cnt)
    );

    function automatic logic cond_true(input logic [3:0] c, input logic z, cy, n, v);
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Registered condition checker seen by the sequencer.
    always @(posedge clk) chk_taken <= cond_true(chk_cond, fz, fc, fn, fv);

    // Expected outputs for one cycle plus counter increments taking effect at its opening edge.
    typedef struct packed {
        logic busy;
        logic rv;
        logic flush;
        logic ready;
        logic inc_t;
        logic inc_nt;
    } rec_t;

    localparam rec_t R_IDLE    = 6'b000100;
    localparam rec_t R_IDLE_NT = 6'b000101;
    localparam rec_t R_BUSY    = 6'b100000;
    localparam rec_t R_REDIR   = 6'b111010;
    localparam rec_t R_FLUSH   = 6'b101000;

    rec_t              sched[$];
    rec_t              cur = R_IDLE;
    bit                m_wait = 1'b0;
    bit                m_accept = 1'b0;
    logic [3:0]        m_cond = '0;
    logic [ADDR_W-1:0] m_target = '0;
    logic [ADDR_W-1:0] m_rpc = '0;
    logic [CNT_W-1:0]  m_taken = '0;
    logic [CNT_W-1:0]  m_nt = '0;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic push_redirect();
        sched.push_back(R_REDIR);
        for (int i = 1; i < FLUSH_CYCLES; i++) sched.push_back(R_FLUSH);
    endtask

    task automatic push_resolve(input logic taken);
        sched.push_back(R_BUSY);
        if (taken) push_redirect();
        else       sched.push_back(R_IDLE_NT);
    endtask

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic model_step();
        rec_t prev;
        prev     = cur;
        m_accept = 1'b0;
        if (!rst_n) begin
            sched.delete();
            m_wait  = 1'b0;
            m_cond  = '0;
            m_rpc   = '0;
            m_taken = '0;
            m_nt    = '0;
            cur     = R_IDLE;
        end else begin
            if (sched.size() > 0) begin
                cur = sched.pop_front();
            end else if (m_wait) begin
                if (flags_pending) begin
                    cur = R_BUSY;
                end else begin
                    m_wait = 1'b0;
                    cur    = R_BUSY;
                    push_resolve(cond_true(m_cond, fz, fc, fn, fv));
                end
            end else if (prev.ready && br_valid) begin
                m_accept = 1'b1;
                m_cond   = br_cond;
                m_target = br_pc + 32'd4 + br_offset;
                if (br_cond == 4'hE) begin
                    push_redirect();
                    cur = sched.pop_front();
                end else if (br_cond == 4'hF) begin
                    cur = R_IDLE_NT;
                end else if (flags_pending) begin
                    m_wait = 1'b1;
                    cur    = R_BUSY;
                end else begin
                    cur = R_BUSY;
                    push_resolve(cond_true(m_cond, fz, fc, fn, fv));
                end
            end else begin
                cur = R_IDLE;
            end
            if (cur.rv) m_rpc = m_target;
            if (clr_stats) begin
                m_taken = '0;
                m_nt    = '0;
            end else begin
                if (cur.inc_t && m_taken != '1) m_taken = m_taken + 1'b1;
                if (cur.inc_nt && m_nt != '1)   m_nt    = m_nt + 1'b1;
            end
        end
    endtask

    task automatic compare();
        check("busy", busy, cur.busy);
        check("br_ready", br_ready, cur.ready & rst_n);
        check("redirect_valid", redirect_valid, cur.rv);
        check("flush", flush, cur.flush);
        check("chk_cond", chk_cond, m_cond);
        check("taken_cnt", taken_cnt, m_taken);
        check("not_taken_cnt", not_taken_cnt, m_nt);
        if (cur.rv) check("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_step();
        compare();
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (!(cur.ready && sched.size() == 0 && !m_wait) && b < 64) begin
            tick();
            b++;
        end
        check("idle_timeout", b < 64, 1);
    endtask

    task automatic run_branch(input logic [3:0] c, input logic [ADDR_W-1:0] pc, off,
                              input int k, input logic [3:0] fl);
        int b;
        {fz, fc, fn, fv} = (k > 0) ? 4'($urandom) : fl;
        br_cond = c; br_pc = pc; br_offset = off;
        flags_pending = (k > 0);
        br_valid = 1'b1;
        b = 0;
        do begin
            tick();
            b++;
        end while (!m_accept && b < 20);
        check("accept_timeout", m_accept, 1);
        br_valid = 1'b0;
        br_cond = 4'($urandom); br_pc = $urandom; br_offset = $urandom;
        for (int i = 1; i < k; i++) begin
            {fz, fc, fn, fv} = 4'($urandom);
            tick();
        end
        flags_pending = 1'b0;
        {fz, fc, fn, fv} = fl;
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, b;

        // Reset
        tick();
        check("rst_ready", br_ready, 0);
        tick();
        check("rst_busy", busy, 0);
        check("rst_flush", flush, 0);
        check("rst_taken", taken_cnt, 0);
        check("rst_chk_cond", chk_cond, 0);
        rst_n = 1'b1;
        tick();

        // 1: BEQ taken, Z=1
        fz = 1'b1;
        br_cond = 4'd0; br_pc = 32'h100; br_offset = 32'h20; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("t1_busy", busy, 1);
        tick();
        check("t1_rv_early", redirect_valid, 0);
        tick();
        check("t1_rv", redirect_valid, 1);
        check("t1_rpc", redirect_pc, 32'h124);
        check("t1_taken", taken_cnt, 1);
        tick();
        check("t1_flush2", flush, 1);
        tick();
        check("t1_flush_end", flush, 0);
        check("t1_ready", br_ready, 1);

        // 2: BNE not taken
        br_cond = 4'd1; br_pc = 32'h200; br_offset = 32'h40; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("t2_busy1", busy, 1);
        tick();
        check("t2_busy2", busy, 1);
        tick();
        check("t2_ready", br_ready, 1);
        check("t2_flush", flush, 0);
        check("t2_nt", not_taken_cnt, 1);

        // 3: BGE behind four pending-flag cycles; flags settle to N=V=1 on release
        fz = 1'b0; fn = 1'b0; fv = 1'b1;
        br_cond = 4'd10; br_pc = 32'h300; br_offset = 32'h10;
        flags_pending = 1'b1; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_wait_busy", busy, 1);
        end
        flags_pending = 1'b0; fn = 1'b1; fv = 1'b1;
        tick();
        tick();
        check("t3_rv_early", redirect_valid, 0);
        tick();
        check("t3_rv", redirect_valid, 1);
        check("t3_rpc", redirect_pc, 32'h314);
        check("t3_taken", taken_cnt, 2);
        wait_idle();

        // 4: unconditional with address wrap, then never
        br_cond = 4'hE; br_pc = 32'hFFFF_FFF8; br_offset = 32'h8; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("t4_rv", redirect_valid, 1);
        check("t4_rpc", redirect_pc, 32'h4);
        check("t4_taken", taken_cnt, 3);
        wait_idle();
        br_cond = 4'hF; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("t4_never_busy", busy, 0);
        check("t4_never_nt", not_taken_cnt, 2);

        // 5: reset in FLUSH, reset in WAIT_FLAGS, then a normal branch
        br_cond = 4'hE; br_pc = 32'h500; br_offset = 32'h0; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        tick();
        check("t5_in_flush", flush, 1);
        rst_n = 1'b0;
        tick();
        check("t5_flush", flush, 0);
        check("t5_rv", redirect_valid, 0);
        check("t5_taken", taken_cnt, 0);
        check("t5_nt", not_taken_cnt, 0);
        rst_n = 1'b1;
        br_cond = 4'd0; flags_pending = 1'b1; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("t5w_busy", busy, 0);
        rst_n = 1'b1; flags_pending = 1'b0; fz = 1'b1;
        br_cond = 4'd0; br_pc = 32'h600; br_offset = 32'hFFFF_FFF0; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        tick();
        tick();
        check("t5_post_rv", redirect_valid, 1);
        check("t5_post_rpc", redirect_pc, 32'h5F4);
        check("t5_post_taken", taken_cnt, 1);
        wait_idle();

        // 6: saturation and clear priority
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("t6_clr", taken_cnt, 0);
        br_cond = 4'hE; br_pc = 32'h700; br_offset = 32'h4; br_valid = 1'b1;
        n_acc = 0; b = 0;
        while (n_acc < 254 && b < 2000) begin
            tick();
            if (m_accept) n_acc++;
            b++;
        end
        br_valid = 1'b0;
        wait_idle();
        check("t6_fe", taken_cnt, 8'hFE);
        br_valid = 1'b1;
        b = 0;
        while (n_acc < 257 && b < 100) begin
            tick();
            if (m_accept) n_acc++;
            b++;
        end
        br_valid = 1'b0;
        wait_idle();
        check("t6_sat", taken_cnt, 8'hFF);
        fz = 1'b1; br_cond = 4'd0; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        tick();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("t6_clr_rv", redirect_valid, 1);
        check("t6_clr_win", taken_cnt, 0);
        wait_idle();

        // Randomized branches
        for (int t = 0; t < 150; t++) begin
            logic [3:0] c;
            int sel, k, gap;
            sel = $urandom_range(0, 9);
            if (sel == 0)      c = 4'hE;
            else if (sel == 1) c = 4'hF;
            else               c = 4'($urandom_range(0, 13));
            k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
            run_branch(c, $urandom, $urandom, k, 4'($urandom));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                clr_stats = ($urandom_range(0, 9) == 0);
                tick();
            end
            clr_stats = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
